// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage for the five-level pipeline CPU.
// Owns the PC, drives the instruction memory read port (combinational
// read, data valid in the same cycle as the address) and captures the
// returned word into the IF/ID pipeline register.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   stall            hold PC and IF/ID (load-use hazard)
//   flush/flush_addr redirect, highest priority, always squashes
//   jump_en/jump_addr taken branch/jump from ID
//   rom_ce/rom_addr  memory enable / byte address (== PC)
//   rom_data         instruction word from memory
//   id_pc/id_inst/id_valid  IF/ID register; id_inst 0 with id_valid 0 = bubble
//   fetch_err        sticky misaligned-redirect fault
//
// Optional feature: define BRANCH_DELAY_SLOT_EN to let the word after a
// taken jump (the delay slot) be captured valid instead of squashed.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;

  // Memory always sees the PC, even when disabled.
  assign rom_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      rom_ce    <= 1'b0;
      id_pc     <= 32'h0;
      id_inst   <= 32'h0;
      id_valid  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          rom_ce   <= 1'b1;
          id_pc    <= pc;
          id_inst  <= 32'h0;
          id_valid <= 1'b0;
        end
        FETCH: begin
          if (flush) begin
            // Squashed slot keeps its pc in id_pc for debug visibility.
            id_pc    <= pc;
            id_inst  <= 32'h0;
            id_valid <= 1'b0;
            if (|flush_addr[1:0]) begin
              state     <= ERR;
              rom_ce    <= 1'b0;
              fetch_err <= 1'b1;
            end else begin
              pc <= flush_addr;
            end
          end else if (stall) begin
            // Hold everything; ID re-asserts any pending jump after the stall.
          end else if (jump_en) begin
            if (|jump_addr[1:0]) begin
              state     <= ERR;
              rom_ce    <= 1'b0;
              fetch_err <= 1'b1;
              id_pc     <= pc;
              id_inst   <= 32'h0;
              id_valid  <= 1'b0;
            end else begin
              pc    <= jump_addr;
              id_pc <= pc;
`ifdef BRANCH_DELAY_SLOT_EN
              id_inst  <= rom_data;
              id_valid <= 1'b1;
`else
              id_inst  <= 32'h0;
              id_valid <= 1'b0;
`endif
            end
          end else begin
            id_pc    <= pc;
            id_inst  <= rom_data;
            id_valid <= 1'b1;
            pc       <= pc + 32'd4;
          end
        end
        ERR: begin
          // Frozen until reset; bubble already loaded on entry.
        end
        default: begin
          state  <= IDLE;
          rom_ce <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        stall, flush, jump_en;
  logic [31:0] flush_addr, jump_addr;
  logic        rom_ce;
  logic [31:0] rom_addr, rom_data;
  logic [31:0] id_pc, id_inst;
  logic        id_valid, fetch_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [1024];

  // Combinational instruction memory: zero when disabled, 4 KB aliasing.
  assign rom_data = rom_ce ? mem[rom_addr[11:2]] : 32'h0;

  inst_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_addr(flush_addr),
    .jump_en(jump_en), .jump_addr(jump_addr), .rom_ce(rom_ce), .rom_addr(rom_addr),
    .rom_data(rom_data), .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid),
    .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  // Reference model: started / faulted flags, pc and the IF/ID contents.
  bit          m_run, m_err;
  logic [31:0] m_pc, m_idpc, m_inst;
  logic        m_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_err = 0; m_pc = 32'h0;
    m_idpc = 32'h0; m_inst = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_bubble();
    m_idpc = m_pc; m_inst = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_edge();
    if (!m_run) begin
      m_run = 1; model_bubble();
    end else if (m_err) begin
    end else if (flush) begin
      model_bubble();
      if (flush_addr[1:0] != 2'b00) m_err = 1;
      else m_pc = flush_addr;
    end else if (stall) begin
    end else if (jump_en) begin
      if (jump_addr[1:0] != 2'b00) begin
        model_bubble(); m_err = 1;
      end else begin
        if (DS) begin
          m_idpc = m_pc; m_inst = mem[m_pc[11:2]]; m_valid = 1'b1;
        end else model_bubble();
        m_pc = jump_addr;
      end
    end else begin
      m_idpc = m_pc; m_inst = mem[m_pc[11:2]]; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rom_ce"},    {31'h0, rom_ce},    {31'h0, m_run && !m_err});
    chk({tag, ".rom_addr"},  rom_addr,           m_pc);
    chk({tag, ".id_pc"},     id_pc,              m_idpc);
    chk({tag, ".id_inst"},   id_inst,            m_inst);
    chk({tag, ".id_valid"},  {31'h0, id_valid},  {31'h0, m_valid});
    chk({tag, ".fetch_err"}, {31'h0, fetch_err}, {31'h0, m_err});
  endtask

  task automatic step(input string tag, input logic s, input logic f, input logic [31:0] fa,
                      input logic j, input logic [31:0] ja);
    stall = s; flush = f; flush_addr = fa; jump_en = j; jump_addr = ja;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Assert reset mid-cycle, check immediate clear, release before next edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2 rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h34011100;
    mem[1] = 32'h34020020;
    stall = 0; flush = 0; jump_en = 0; flush_addr = 0; jump_addr = 0;
    rst = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;
    #1;
    chk("pre_edge.rom_ce", {31'h0, rom_ce}, 32'h0);

    // Reset release and first fetches
    step("edge1", 0, 0, 0, 0, 0);
    chk("edge1.rom_ce", {31'h0, rom_ce}, 32'h1);
    step("edge2", 0, 0, 0, 0, 0);
    chk("edge2.inst", id_inst, 32'h34011100);
    chk("edge2.pc", id_pc, 32'h0);
    step("edge3", 0, 0, 0, 0, 0);
    chk("edge3.inst", id_inst, 32'h34020020);
    chk("edge3.pc", id_pc, 32'h4);

    // Stall two cycles at pc=8
    step("stall1", 1, 0, 0, 0, 0);
    step("stall2", 1, 0, 0, 0, 0);
    chk("stall.addr", rom_addr, 32'h8);
    chk("stall.inst", id_inst, 32'h34020020);
    step("resume", 0, 0, 0, 0, 0);
    chk("resume.pc", id_pc, 32'h8);

    // Jump to 0x20 issued while pc=12
    step("jump", 0, 0, 0, 1, 32'h20);
    chk("jump.valid", {31'h0, id_valid}, {31'h0, DS});
    step("jump_tgt", 0, 0, 0, 0, 0);
    chk("jump_tgt.pc", id_pc, 32'h20);

    // Flush beats jump and stall
    step("flush_pri", 1, 1, 32'h40, 1, 32'h20);
    chk("flush_pri.addr", rom_addr, 32'h40);
    chk("flush_pri.valid", {31'h0, id_valid}, 32'h0);
    step("after_flush", 0, 0, 0, 0, 0);

    // PC wrap at the top of the address space
    step("flush_top", 0, 1, 32'hFFFF_FFFC, 0, 0);
    step("wrap", 0, 0, 0, 0, 0);
    chk("wrap.addr", rom_addr, 32'h0);
    chk("wrap.pc", id_pc, 32'hFFFF_FFFC);

    // Randomized traffic with occasional faults and async resets
    for (int c = 0; c < 600; c++) begin
      int r;
      logic s, f, j;
      logic [31:0] fa, ja;
      r  = $urandom_range(0, 99);
      s  = ($urandom_range(0, 3) == 0);
      f  = (r < 6);
      j  = ($urandom_range(0, 5) == 0);
      fa = {20'h0, $urandom_range(0, 1023), 2'b00};
      ja = {$urandom_range(0, 1) ? 20'hFFFFF : 20'h0, $urandom_range(0, 1023), 2'b00};
      if ($urandom_range(0, 59) == 0) fa[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 59) == 0) ja[1:0] = 2'($urandom_range(1, 3));
      step("rand", s, f, fa, j, ja);
      if ($urandom_range(0, 49) == 0 || (m_err && $urandom_range(0, 7) == 0))
        async_reset("rand_rst");
    end

    // Misaligned jump fault, sticky, then asynchronous clear
    async_reset("pre_err_rst");
    step("e1", 0, 0, 0, 0, 0);
    step("e2", 0, 0, 0, 0, 0);
    step("e3", 0, 0, 0, 0, 0);
    step("jmp_bad", 0, 0, 0, 1, 32'h22);
    chk("jmp_bad.err", {31'h0, fetch_err}, 32'h1);
    chk("jmp_bad.ce", {31'h0, rom_ce}, 32'h0);
    step("err_hold1", 0, 0, 0, 0, 0);
    step("err_hold2", 0, 1, 32'h40, 1, 32'h20);
    chk("err_hold.valid", {31'h0, id_valid}, 32'h0);
    chk("err_hold.inst", id_inst, 32'h0);
    async_reset("err_rst");
    chk("err_rst.err", {31'h0, fetch_err}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the five-level pipeline CPU. It owns the program counter and drives the instruction memory's `ce`/`addr` read port, then captures the returned word into the IF/ID pipeline register for decode. It applies stall, flush and jump redirects from the rest of the pipeline, and it faults on misaligned targets. The instruction memory read is combinational: `data` is valid in the same cycle as `addr`.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `stall`  in  1  hold request from the control unit (load-use hazard).
- `flush`  in  1  redirect from exception/control; highest priority.
- `flush_addr`  in  32  redirect target used with `flush`.
- `jump_en`  in  1  branch/jump taken, from ID.
- `jump_addr`  in  32  branch/jump target, from ID.
- `rom_ce`  out  1  instruction memory enable (1 = enabled).
- `rom_addr`  out  32  byte address to instruction memory; equals current PC.
- `rom_data`  in  32  instruction word returned by memory.
- `id_pc`  out  32  PC of the instruction in IF/ID.
- `id_inst`  out  32  instruction in IF/ID; 32'h0 is a bubble (nop).
- `id_valid`  out  1  IF/ID holds a real instruction.
- `fetch_err`  out  1  misaligned redirect target seen; sticky until reset.

## Operation
- FSM states:
  - IDLE: `rom_ce`=0.
  - FETCH: `rom_ce`=1.
  - ERR: `rom_ce`=0, `fetch_err`=1.
- Reset (`rst`=0, asynchronous):
  - state=IDLE, pc=`RESET_PC`.
  - `id_pc`=0, `id_inst`=0, `id_valid`=0, `fetch_err`=0.
- IDLE -> FETCH on the first edge with `rst`=1. IF/ID loads a bubble on that edge.
- Action priority in FETCH, evaluated per edge:
  1. `flush`:
     - If `flush_addr[1:0]`!=0: go to ERR.
     - Otherwise: pc<=`flush_addr` and IF/ID<=bubble.
     - `stall` and `jump_en` are ignored.
  2. `stall`: pc and IF/ID hold. `jump_en` is ignored (ID holds and re-asserts it).
  3. `jump_en`:
     - If `jump_addr[1:0]`!=0: go to ERR.
     - Otherwise: pc<=`jump_addr`. IF/ID loads according to the delay-slot rule (see Configuration).
  4. Default:
     - IF/ID<={pc, `rom_data`, valid=1}.
     - pc<=pc+4 (32-bit modular; 32'hFFFF_FFFC wraps to 0).
- ERR:
  - IF/ID loads a bubble on entry and holds it.
  - pc freezes at its last value.
  - Only reset exits.
- Bubble = `id_inst` 32'h0, `id_valid` 0. `id_pc` is the pc of the squashed slot.
- `rom_addr` = pc at all times, including IDLE and ERR. Memory ignores it when `rom_ce`=0 and returns zero.
- Memory aliasing above 4 KB (only addr[11:2] decoded) is a memory property. This block does not check it.

## Timing
- `rom_ce`, `rom_addr` and IF/ID outputs are registered. `rom_data` is sampled at the edge that ends the fetch cycle.
- Fetch latency: an instruction at pc appears on `id_inst` one edge after pc is presented.
- First valid instruction: on the 2nd rising edge after `rst` deasserts (1st edge IDLE->FETCH, 2nd edge captures word at `RESET_PC`).
- Throughput: one instruction per cycle when there is no stall or redirect.
- Redirect penalty:
  - 1 bubble without the delay slot.
  - 0 bubbles with the delay slot.
- `flush` and `jump_en` in the same cycle: `flush` wins and the jump is dropped.
- Reset asserted mid-stall or mid-redirect: all state clears immediately (asynchronous), independent of `clk`.

## Configuration
- `BRANCH_DELAY_SLOT_EN` defined: on a taken `jump_en`, the word at pc (branch+4) is captured valid into IF/ID, i.e. the delay slot executes.
- Not defined: that word is squashed and IF/ID loads a bubble.
- `flush` always squashes, regardless of the macro.

## Test plan
- Reset release, memory word0=32'h34011100, word1=32'h34020020:
  - `rom_ce` 0 then 1.
  - Edge 2: `id_inst`=32'h34011100, `id_pc`=0, `id_valid`=1.
  - Edge 3: `id_inst`=32'h34020020, `id_pc`=4.
- `stall` high for 2 cycles at pc=8: `rom_addr` stays 8 and `id_inst` holds for 2 edges. Sequence resumes with pc=8 fetched next, with no loss and no duplication.
- `jump_en`, `jump_addr`=32'h20, issued while pc=12:
  - With the macro: `id_pc`=12 valid, then `id_pc`=32'h20.
  - Without it: a bubble (`id_inst`=0, `id_valid`=0), then `id_pc`=32'h20.
- `flush`, `flush_addr`=32'h40, together with `jump_en`, `jump_addr`=32'h20 and `stall`=1: next pc=32'h40, IF/ID=bubble.
- `jump_addr`=32'h22: `fetch_err`=1, `rom_ce`=0, bubbles persist. Asserting `rst`=0 mid-cycle clears all outputs at once.
- pc forced near the top (flush to 32'hFFFF_FFFC): the next sequential pc is 32'h0000_0000.
